// File: rtl/pc_mon_pkg.sv
// Shared types and helpers for the PC trace monitor.
// Build option PC_MON_ALIGN_CHECK_EN is consumed by pc_trace_monitor.
package pc_mon_pkg;

    typedef enum logic [1:0] {
        PCM_IDLE,
        PCM_RUN,
        PCM_HALTED,
        PCM_TIMEOUT
    } pcm_state_e;

    // Index width for a DEPTH-entry trace; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Circular PC trace buffer: write pointer, saturating entry count and a
// registered read port indexed relative to the newest entry.
module pc_trace_buf
    import pc_mon_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [idx_w(DEPTH)-1:0]  rd_idx,
    output logic [XLEN-1:0]          rd_data,
    output logic [idx_w(DEPTH):0]    count
);

    localparam int unsigned IW = idx_w(DEPTH);
    localparam logic [IW:0] FULL = (IW + 1)'(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [IW-1:0]   wr_ptr_q;
    logic [IW:0]     count_q;
    logic [XLEN-1:0] rd_data_q;
    logic [IW-1:0]   rd_addr;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign rd_addr = wr_ptr_q - IW'(1) - rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else if (clr) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + IW'(1);
                if (count_q != FULL) begin
                    count_q <= count_q + (IW + 1)'(1);
                end
            end
            rd_data_q <= ({1'b0, rd_idx} >= count_q) ? '0 : mem_q[rd_addr];
        end
    end

    // Storage is not reset; stale entries are masked by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor: traces distinct PC values and flags halt / timeout.
// Define PC_MON_ALIGN_CHECK_EN to enable the sticky misaligned-PC flag.
module pc_trace_monitor
    import pc_mon_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned HALT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run_en,
    input  logic                     clr,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [idx_w(DEPTH)-1:0]  rd_idx,
    output logic [XLEN-1:0]          rd_data,
    output logic [idx_w(DEPTH):0]    trace_count,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     halted,
    output logic                     timeout,
    output logic                     misaligned
);

    localparam int unsigned SW = $clog2(HALT_CYCLES + 1);
    localparam logic [SW-1:0]    STALL_LAST = SW'(HALT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

    pcm_state_e      state_q, state_d;
    logic [XLEN-1:0] prev_pc_q;
    logic [SW-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;
    logic            pc_change, halt_hit, timeout_hit, trace_wr;

    // cycle_q is zero only on the first RUN sample, which always counts as a change.
    assign pc_change   = (cycle_q == '0) || (pc_in != prev_pc_q);
    assign halt_hit    = !pc_change && (stall_q == STALL_LAST);
    assign timeout_hit = (cycle_q + CNT_W'(1)) == CYC_LIMIT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PCM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = PCM_IDLE;
        end else begin
            unique case (state_q)
                PCM_IDLE:    if (run_en) state_d = PCM_RUN;
                PCM_RUN: begin
                    if (halt_hit) begin
                        state_d = PCM_HALTED;
                    end else if (timeout_hit) begin
                        state_d = PCM_TIMEOUT;
                    end
                end
                PCM_HALTED:  state_d = PCM_HALTED;
                PCM_TIMEOUT: state_d = PCM_TIMEOUT;
            endcase
        end
    end

    always_comb begin
        trace_wr  = 1'b0;
        stall_d   = stall_q;
        cycle_d   = cycle_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        if (clr) begin
            stall_d   = '0;
            cycle_d   = '0;
            halted_d  = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == PCM_RUN) begin
            trace_wr = pc_change;
            stall_d  = pc_change ? '0 : stall_q + SW'(1);
            cycle_d  = cycle_q + CNT_W'(1);
            // Halt wins when both qualify on the same edge.
            if (halt_hit) begin
                halted_d = 1'b1;
            end else if (timeout_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc_q <= '0;
            stall_q   <= '0;
            cycle_q   <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (!clr && state_q == PCM_RUN) begin
                prev_pc_q <= pc_in;
            end
            stall_q   <= stall_d;
            cycle_q   <= cycle_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    pc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (trace_wr),
        .wr_data (pc_in),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .count   (trace_count)
    );

`ifdef PC_MON_ALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (clr) begin
            misaligned_q <= 1'b0;
        end else if (state_q == PCM_RUN && pc_in[1:0] != 2'b00) begin
            misaligned_q <= 1'b1;
        end
    end

    assign misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

    assign cycle_count = cycle_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor: vector table plus multi-cycle sequences.
module tb_pc_trace_monitor;
    import pc_mon_pkg::*;

    logic        clk;
    logic        reset;
    logic        run_en;
    logic        clr;
    logic [31:0] pc_in;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic [3:0]  trace_count;
    logic [31:0] cycle_count;
    logic        halted;
    logic        timeout;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

`ifdef PC_MON_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    pc_trace_monitor #(
        .XLEN           (32),
        .DEPTH          (8),
        .HALT_CYCLES    (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run_en      (run_en),
        .clr         (clr),
        .pc_in       (pc_in),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .trace_count (trace_count),
        .cycle_count (cycle_count),
        .halted      (halted),
        .timeout     (timeout),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        run_en;
        logic [31:0] pc;
        logic [2:0]  rd_idx;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_cyc;
        logic        exp_halted;
        logic        exp_timeout;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_data"}, 64'(rd_data), 64'h0);
        chk({tag, " trace_count"}, 64'(trace_count), 64'h0);
        chk({tag, " cycle_count"}, 64'(cycle_count), 64'h0);
        chk({tag, " halted"}, 64'(halted), 64'h0);
        chk({tag, " timeout"}, 64'(timeout), 64'h0);
        chk({tag, " misaligned"}, 64'(misaligned), 64'h0);
        chk({tag, " state"}, 64'(dut.state_q), 64'(PCM_IDLE));
    endtask

    initial begin
        // Linear program: clr row (clr beats run_en), entry edge, five PCs, then holds.
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_FFFC, 3'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_FFFC, 3'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0,  3'd0, 4'd1, 32'd1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h4,  3'd0, 4'd2, 32'd2, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h8,  3'd0, 4'd3, 32'd3, 1'b0, 1'b0, 32'h4};
        vecs[5]  = '{1'b0, 1'b1, 32'hC,  3'd0, 4'd4, 32'd4, 1'b0, 1'b0, 32'h8};
        vecs[6]  = '{1'b0, 1'b1, 32'h10, 3'd0, 4'd5, 32'd5, 1'b0, 1'b0, 32'hC};
        vecs[7]  = '{1'b0, 1'b1, 32'h10, 3'd0, 4'd5, 32'd6, 1'b0, 1'b0, 32'h10};
        vecs[8]  = '{1'b0, 1'b1, 32'h10, 3'd4, 4'd5, 32'd7, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h10, 3'd5, 4'd5, 32'd8, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h10, 3'd2, 4'd5, 32'd9, 1'b1, 1'b0, 32'h8};
        vecs[11] = '{1'b0, 1'b1, 32'h10, 3'd1, 4'd5, 32'd9, 1'b1, 1'b0, 32'hC};

        // Reset then idle
        reset  = 1'b1;
        run_en = 1'b0;
        clr    = 1'b0;
        pc_in  = 32'h0;
        rd_idx = 3'd0;
        for (int i = 0; i < 2; i++) begin
            pc_in = ~pc_in;
            step();
            chk_all_zero("reset");
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = pc_in + 32'h4;
            step();
        end
        chk_all_zero("idle");

        // Linear program from the vector table
        for (int i = 0; i < 12; i++) begin
            clr    = vecs[i].clr;
            run_en = vecs[i].run_en;
            pc_in  = vecs[i].pc;
            rd_idx = vecs[i].rd_idx;
            step();
            chk($sformatf("vec%0d trace_count", i), 64'(trace_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d cycle_count", i), 64'(cycle_count), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].exp_halted));
            chk($sformatf("vec%0d timeout", i), 64'(timeout), 64'(vecs[i].exp_timeout));
            chk($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(vecs[i].exp_rd));
        end

        // Halt: 0x0 on entry edge, then 0x4, then 0x8 held
        clr = 1'b1; step(); clr = 1'b0;
        run_en = 1'b1; pc_in = 32'h0; step();
        run_en = 1'b0;
        pc_in = 32'h4; step();
        pc_in = 32'h8; step();
        for (int e = 3; e <= 8; e++) begin
            step();
            chk($sformatf("halt e%0d halted", e), 64'(halted), 64'(e >= 6));
            chk($sformatf("halt e%0d cycle", e), 64'(cycle_count), 64'((e < 6) ? e : 6));
        end
        chk("halt timeout", 64'(timeout), 64'h0);
        chk("halt trace_count", 64'(trace_count), 64'd2);
        chk("halt state", 64'(dut.state_q), 64'(PCM_HALTED));

        // clr from HALTED
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr halted", 64'(halted), 64'h0);
        chk("clr timeout", 64'(timeout), 64'h0);
        chk("clr cycle", 64'(cycle_count), 64'h0);
        chk("clr trace_count", 64'(trace_count), 64'h0);
        chk("clr state", 64'(dut.state_q), 64'(PCM_IDLE));
        pc_in = 32'h44; step();
        chk("clr stays idle", 64'(dut.state_q), 64'(PCM_IDLE));

        // Timeout with ever-changing PC
        run_en = 1'b1; pc_in = 32'h100; step();
        run_en = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            pc_in = 32'h200 + 32'(4 * e);
            step();
            chk($sformatf("to e%0d timeout", e), 64'(timeout), 64'(e >= 16));
            chk($sformatf("to e%0d cycle", e), 64'(cycle_count), 64'((e < 16) ? e : 16));
        end
        chk("to halted", 64'(halted), 64'h0);
        chk("to trace_count", 64'(trace_count), 64'd8);

        // Wrap (12 PCs), then hold so halt and timeout coincide at edge 16
        clr = 1'b1; step(); clr = 1'b0;
        run_en = 1'b1; pc_in = 32'hABC0; step();
        run_en = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            pc_in = 32'(4 * (e - 1));
            step();
        end
        chk("wrap trace_count", 64'(trace_count), 64'd8);
        chk("wrap cycle", 64'(cycle_count), 64'd12);
        rd_idx = 3'd0; step();
        chk("wrap rd0", 64'(rd_data), 64'h2C);
        rd_idx = 3'd7; step();
        chk("wrap rd7", 64'(rd_data), 64'h10);
        rd_idx = 3'd3; step();
        chk("wrap rd3", 64'(rd_data), 64'h20);
        chk("sim pre halted", 64'(halted), 64'h0);
        step();
        chk("sim halted", 64'(halted), 64'h1);
        chk("sim timeout", 64'(timeout), 64'h0);
        chk("sim cycle", 64'(cycle_count), 64'd16);

        // Async reset between edges during RUN
        clr = 1'b1; step(); clr = 1'b0;
        rd_idx = 3'd0;
        run_en = 1'b1; pc_in = 32'h40; step();
        run_en = 1'b0;
        pc_in = 32'h44; step();
        pc_in = 32'h48; step();
        chk("pre-reset cycle", 64'(cycle_count), 64'd2);
        chk("pre-reset rd_data", 64'(rd_data), 64'h44);
        #2 reset = 1'b1;
        #1 chk_all_zero("async reset");
        #1 reset = 1'b0;
        step();
        chk("post-reset state", 64'(dut.state_q), 64'(PCM_IDLE));

        // Misaligned PC (flag present only with the alignment check built in)
        run_en = 1'b1; pc_in = 32'h0; step();
        run_en = 1'b0;
        pc_in = 32'h4; step();
        chk("aligned misaligned", 64'(misaligned), 64'h0);
        pc_in = 32'h6; step();
        chk("misaligned set", 64'(misaligned), 64'(ALIGN_EN));
        pc_in = 32'h8; step();
        chk("misaligned sticky", 64'(misaligned), 64'(ALIGN_EN));
        chk("misaligned state", 64'(dut.state_q), 64'(PCM_RUN));
        clr = 1'b1; step(); clr = 1'b0;
        chk("misaligned clr", 64'(misaligned), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
